// File: rtl/hnf_pocq.sv
//-----------------------------------------------------------------------------
// Module   : hnf_pocq
// Brief    : HN-F point-of-coherency queue; credit-controlled RXREQ ingress FIFO.
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package hnf_pocq_pkg;
   typedef struct packed {
      logic [3:0]  qos;
      logic [6:0]  tgt_id;
      logic [6:0]  src_id;
      logic [7:0]  txn_id;
      logic [5:0]  opcode;
      logic [2:0]  size;
      logic [47:0] addr;
      logic        ns;
      logic [1:0]  order;
      logic [3:0]  mem_attr;
   } reqflit_t;
endpackage

module hnf_pocq
   import hnf_pocq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rxreq_flitv,
   input  reqflit_t         rxreq_flit,
   output logic             rxreq_lcrdv,
   output reqflit_t         rxreq_pocq_first_entry,
   output logic             rxreq_pocq_entry_v,
   input  logic             pocq_pop,
   output logic [PTR_W:0]   pocq_count,
   output logic             pocq_ovf_err
);

   localparam int          c_cw    = PTR_W + 1;
   localparam [PTR_W:0]    c_depth = c_cw'(DEPTH);

   reqflit_t               r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W:0]         r_count;
   logic [PTR_W:0]         r_crd_out;
   logic [PTR_W:0]         r_crd_pending;
   logic                   r_lcrdv;
   logic                   r_ovf_err;

   logic                   w_push;
   logic                   w_pop;
   logic                   w_ovf;
   logic [PTR_W:0]         w_p;

   // The credit invariant guarantees a credited flit always has a free slot.
   assign w_push = rxreq_flitv && (r_crd_out != '0);
   assign w_ovf  = rxreq_flitv && (r_crd_out == '0);
   assign w_pop  = pocq_pop && (r_count != '0);
   assign w_p    = r_crd_pending + c_cw'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_crd_out     <= '0;
         r_crd_pending <= c_depth;
         r_lcrdv       <= 1'b0;
         r_ovf_err     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
         // One credit per cycle; returned credits queue behind the backlog.
         r_lcrdv       <= (w_p != '0);
         r_crd_pending <= w_p - c_cw'(w_p != '0);
         r_crd_out     <= r_crd_out + c_cw'(r_lcrdv) - c_cw'(w_push);
         if (w_ovf) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

   // Payload storage carries no reset; validity is tracked by the counters.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rxreq_flit;
      end
   end

   assign rxreq_lcrdv            = r_lcrdv;
   assign rxreq_pocq_first_entry = r_mem[r_rd_ptr];
   assign rxreq_pocq_entry_v     = (r_count != '0);
   assign pocq_count             = r_count;
   assign pocq_ovf_err           = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_hnf_pocq.sv
//-----------------------------------------------------------------------------
// Module   : tb_hnf_pocq
// Brief    : Directed self-checking bench for hnf_pocq (DEPTH = 8).
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_hnf_pocq;
   import hnf_pocq_pkg::*;

   localparam int c_depth = 8;
   localparam int c_pw    = 3;

   logic             clk;
   logic             rst_n;
   logic             rxreq_flitv;
   reqflit_t         rxreq_flit;
   logic             rxreq_lcrdv;
   reqflit_t         rxreq_pocq_first_entry;
   logic             rxreq_pocq_entry_v;
   logic             pocq_pop;
   logic [c_pw:0]    pocq_count;
   logic             pocq_ovf_err;

   int               n_checks;
   int               n_pass;
   int               n_crd;

   hnf_pocq #(.DEPTH(c_depth)) u_dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .rxreq_flitv            (rxreq_flitv),
      .rxreq_flit             (rxreq_flit),
      .rxreq_lcrdv            (rxreq_lcrdv),
      .rxreq_pocq_first_entry (rxreq_pocq_first_entry),
      .rxreq_pocq_entry_v     (rxreq_pocq_entry_v),
      .pocq_pop               (pocq_pop),
      .pocq_count             (pocq_count),
      .pocq_ovf_err           (pocq_ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic drive_flit(input logic [47:0] addr);
      rxreq_flit        = '0;
      rxreq_flit.addr   = addr;
      rxreq_flit.opcode = 6'h04;
      rxreq_flit.txn_id = addr[13:6];
      rxreq_flitv       = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lcrdv"}, 64'(rxreq_lcrdv), 64'd0);
      check({tag, "_entry_v"}, 64'(rxreq_pocq_entry_v), 64'd0);
      check({tag, "_count"}, 64'(pocq_count), 64'd0);
      check({tag, "_ovf"}, 64'(pocq_ovf_err), 64'd0);
   endtask

   // Counts lcrdv over 10 cycles after release; high exactly in cycles 1..8.
   task automatic check_credit_ramp(input string tag);
      n_crd = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check({tag, "_lcrdv_cyc"}, 64'(rxreq_lcrdv), 64'(i <= c_depth));
         if (rxreq_lcrdv) n_crd++;
      end
      check({tag, "_lcrdv_total"}, 64'(n_crd), 64'(c_depth));
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      rxreq_flitv = 1'b0;
      rxreq_flit  = '0;
      pocq_pop    = 1'b0;

      // Reset and initial credit ramp.
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      check_credit_ramp("ramp0");
      check("ramp0_entry_v", 64'(rxreq_pocq_entry_v), 64'd0);
      check("ramp0_count", 64'(pocq_count), 64'd0);

      // Credit-respecting burst of 8, no pops.
      for (int i = 0; i < 8; i++) begin
         drive_flit(48'h1000 + 48'(i * 'h40));
         @(negedge clk);
         check("burst_no_lcrdv", 64'(rxreq_lcrdv), 64'd0);
      end
      rxreq_flitv = 1'b0;
      check("burst_count", 64'(pocq_count), 64'd8);
      check("burst_head", 64'(rxreq_pocq_first_entry.addr), 64'h1000);
      check("burst_entry_v", 64'(rxreq_pocq_entry_v), 64'd1);
      check("burst_ovf", 64'(pocq_ovf_err), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("burst_idle_lcrdv", 64'(rxreq_lcrdv), 64'd0);
      end

      // Drain one per cycle; each pop returns a credit the next cycle.
      for (int i = 0; i < 8; i++) begin
         check("drain_head", 64'(rxreq_pocq_first_entry.addr), 64'h1000 + 64'(i * 'h40));
         check("drain_count", 64'(pocq_count), 64'(8 - i));
         pocq_pop = 1'b1;
         @(negedge clk);
         check("drain_lcrdv", 64'(rxreq_lcrdv), 64'd1);
      end
      pocq_pop = 1'b0;
      check("drain_entry_v", 64'(rxreq_pocq_entry_v), 64'd0);
      check("drain_count_end", 64'(pocq_count), 64'd0);

      // Single entry, then push+pop together across pointer wrap.
      drive_flit(48'h2000);
      @(negedge clk);
      rxreq_flitv = 1'b0;
      check("one_entry_v", 64'(rxreq_pocq_entry_v), 64'd1);
      check("one_head", 64'(rxreq_pocq_first_entry.addr), 64'h2000);
      for (int j = 0; j < 20; j++) begin
         drive_flit(48'h2000 + 48'((j + 1) * 'h40));
         pocq_pop = 1'b1;
         @(negedge clk);
         check("wrap_count", 64'(pocq_count), 64'd1);
         check("wrap_head", 64'(rxreq_pocq_first_entry.addr), 64'h2000 + 64'((j + 1) * 'h40));
         check("wrap_lcrdv", 64'(rxreq_lcrdv), 64'd1);
      end
      rxreq_flitv = 1'b0;
      @(negedge clk);
      pocq_pop = 1'b0;
      repeat (3) @(negedge clk);
      check("wrap_end_count", 64'(pocq_count), 64'd0);
      check("wrap_end_ovf", 64'(pocq_ovf_err), 64'd0);

      // Exhaust credits, then drive an uncredited flit.
      for (int i = 0; i < 8; i++) begin
         drive_flit(48'h3000 + 48'(i * 'h40));
         @(negedge clk);
      end
      check("fill_count", 64'(pocq_count), 64'd8);
      check("fill_ovf", 64'(pocq_ovf_err), 64'd0);
      drive_flit(48'h5000);
      @(negedge clk);
      rxreq_flitv = 1'b0;
      check("ovf_count", 64'(pocq_count), 64'd8);
      check("ovf_set", 64'(pocq_ovf_err), 64'd1);
      pocq_pop = 1'b1;
      @(negedge clk);
      pocq_pop = 1'b0;
      check("ovf_pop_head", 64'(rxreq_pocq_first_entry.addr), 64'h3040);
      check("ovf_pop_count", 64'(pocq_count), 64'd7);
      check("ovf_sticky", 64'(pocq_ovf_err), 64'd1);
      repeat (2) @(negedge clk);
      check("ovf_sticky_idle", 64'(pocq_ovf_err), 64'd1);

      // Reset clears sticky error; rebuild 5 entries during the credit ramp.
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst1");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         drive_flit(48'h4000 + 48'(i * 'h40));
         @(negedge clk);
      end
      rxreq_flitv = 1'b0;
      check("mid_count", 64'(pocq_count), 64'd5);
      check("mid_head", 64'(rxreq_pocq_first_entry.addr), 64'h4000);
      check("mid_lcrdv", 64'(rxreq_lcrdv), 64'd1);
      check("mid_ovf", 64'(pocq_ovf_err), 64'd0);

      // Asynchronous reset mid-operation, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      check_credit_ramp("ramp2");
      check("ramp2_count", 64'(pocq_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
